// File: rtl/mem_access_unit_if.sv
// Request/response and data-memory port bundle for mem_access_unit.
// slave: the access unit itself; master: the requester/memory environment.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_read;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_read, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready, resp_valid, resp_data, resp_err,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_read, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready, resp_valid, resp_data, resp_err,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store front end for a word-only data memory.
// Define MEM_ACCESS_BOUNDS_CHECK_EN to reject word indices >= MEM_WORDS.
module mem_access_unit #(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus
);

`ifdef MEM_ACCESS_BOUNDS_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, LD, ST, RMW_RD, RMW_WR, ERR} state_t;

  state_t      state_q;
  logic [1:0]  addr_lo_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;

  logic        req_ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic        resp_err_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        req_err;
  logic [31:0] lane_shift;
  logic [31:0] load_data_d;
  logic [31:0] merge_word_d;

  assign req_err = (bus.req_read == bus.req_write)
                || (bus.req_size == 2'b11)
                || ((bus.req_size == 2'b01) && bus.req_addr[0])
                || ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00))
                || (RANGE_CHECK && ({2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS)));

  // Move the addressed lane(s) down to bit 0 before extension.
  assign lane_shift = bus.mem_rdata >> {addr_lo_q, 3'b000};

  always_comb begin
    load_data_d = bus.mem_rdata;
    case (size_q)
      2'b00:   load_data_d = unsigned_q ? {24'h0, lane_shift[7:0]}
                                        : {{24{lane_shift[7]}}, lane_shift[7:0]};
      2'b01:   load_data_d = unsigned_q ? {16'h0, lane_shift[15:0]}
                                        : {{16{lane_shift[15]}}, lane_shift[15:0]};
      default: load_data_d = bus.mem_rdata;
    endcase
  end

  // Read-modify-write merge: replace only the targeted byte lanes.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       lane_hit;
      logic [7:0] lane_src;
      assign lane_hit = (size_q == 2'b00) ? (addr_lo_q == 2'(gi))
                                          : (addr_lo_q[1] == 1'(gi / 2));
      assign lane_src = (((gi % 2) == 1) && (size_q == 2'b01)) ? wdata_q[15:8] : wdata_q[7:0];
      assign merge_word_d[8*gi +: 8] = lane_hit ? lane_src : bus.mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_lo_q    <= 2'b00;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      wdata_q      <= 32'h0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            req_ready_q <= 1'b0;
            addr_lo_q   <= bus.req_addr[1:0];
            size_q      <= bus.req_size;
            unsigned_q  <= bus.req_unsigned;
            wdata_q     <= bus.req_wdata;
            mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
            if (req_err) begin
              state_q <= ERR;
            end else if (bus.req_read) begin
              state_q    <= LD;
              mem_read_q <= 1'b1;
            end else if (bus.req_size == 2'b10) begin
              state_q     <= ST;
              mem_write_q <= 1'b1;
              mem_wdata_q <= bus.req_wdata;
            end else begin
              state_q    <= RMW_RD;
              mem_read_q <= 1'b1;
            end
          end
        end
        LD: begin
          state_q      <= IDLE;
          mem_read_q   <= 1'b0;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b1;
          resp_data_q  <= load_data_d;
          resp_err_q   <= 1'b0;
        end
        RMW_RD: begin
          state_q     <= RMW_WR;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b1;
          mem_wdata_q <= merge_word_d;
        end
        ST, RMW_WR: begin
          state_q      <= IDLE;
          mem_write_q  <= 1'b0;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b1;
          resp_data_q  <= 32'h0;
          resp_err_q   <= 1'b0;
        end
        ERR: begin
          state_q      <= IDLE;
          req_ready_q  <= 1'b1;
          resp_valid_q <= 1'b1;
          resp_data_q  <= 32'h0;
          resp_err_q   <= 1'b1;
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store front end that sits directly upstream of data_memory. It takes byte, halfword and word requests from the EX/MEM stage and drives the word-only data memory port.
- Sub-word stores are done as a two-cycle read-modify-write. Sub-word loads are sign- or zero-extended.
- Misaligned, invalid and out-of-range requests are reported as errors. The pipeline stalls on req_ready.

Parameters:
- MEM_WORDS, 32, number of 32-bit words in the attached data memory; word index = addr[31:2].

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request this cycle
- req_read  input  1  load request
- req_write  input  1  store request
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 invalid
- req_unsigned  input  1  zero-extend loads (lbu/lhu) when 1, sign-extend when 0
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_data  output  32  extended load data; 0 for stores and errors
- resp_err  output  1  request rejected; valid with resp_valid
- mem_read  output  1  to data_memory MemRead
- mem_write  output  1  to data_memory MemWrite
- mem_addr  output  32  {addr[31:2],2'b00}
- mem_wdata  output  32  to data_memory write_data
- mem_rdata  input  32  from data_memory read_data (combinational)

Behaviour:
- Reset values: all outputs 0 except req_ready=1; state=IDLE.
- Memory port: mem_* are driven only from registered state and latched request fields, never from req_* directly.
- Byte lanes are little-endian: byte k occupies bits [8k+7:8k], with k=addr[1:0].
- Request acceptance: a request is accepted when req_valid && req_ready.
- req_ready is 1 only in IDLE. It goes 1 again in the same cycle that resp_valid pulses, so back-to-back requests are possible.
- Accepted fields are latched into internal registers.
- Error check on acceptance. Any of the following is an error:
  - req_read==req_write (both set or both clear)
  - size==11
  - halfword with addr[0]!=0
  - word with addr[1:0]!=0
  - addr[31:2]>=MEM_WORDS (see Optional Feature)
- FSM states: IDLE, LD, ST, RMW_RD, RMW_WR, ERR.
- IDLE -> ERR: error request. No mem_read or mem_write is ever asserted. ERR lasts 1 cycle; resp_valid=1, resp_err=1, resp_data=0 on the next cycle.
- IDLE -> LD: load. In LD, mem_read=1 and mem_rdata is extracted and extended at the LD clock edge.
  - resp_valid pulses on the cycle after LD, so load latency is 2 cycles from acceptance.
  - Byte extracts lane addr[1:0]; halfword extracts lane pair addr[1].
- IDLE -> ST: word store. In ST, mem_write=1 and mem_wdata=wdata. resp_valid pulses on the next cycle (latency 2).
- IDLE -> RMW_RD: byte or halfword store.
  - RMW_RD: mem_read=1. The merged word is captured: mem_rdata with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
  - RMW_WR: mem_write=1 with the merged word. resp_valid pulses on the next cycle (latency 3).
- Store responses: resp_data=0, resp_err=0.
- mem_read and mem_write are never high in the same cycle.
- mem_addr holds the latched aligned address for the whole access.
- resp_valid is a single-cycle pulse; resp_data and resp_err hold their value until the next response.
- Requests presented while req_ready=0 are ignored and not latched. The requester must hold them.
- rst asserted mid-operation: immediately returns to IDLE and clears mem_write/mem_read asynchronously. No partial write is committed and no resp_valid is generated for the aborted request.

Optional Feature:
- Macro MEM_ACCESS_BOUNDS_CHECK_EN.
- Defined: addr[31:2]>=MEM_WORDS is an error, handled through ERR exactly as a misaligned access.
- Undefined: no range check; the address is passed through and data_memory's own indexing determines wrap.

Test Plan:
- Word store then load: sw 0xDEADBEEF at 0x10; lw 0x10 -> mem_write exactly 1 cycle at mem_addr 0x10; lw resp_valid 2 cycles after acceptance with resp_data 0xDEADBEEF.
- Byte RMW: sb 0x7F at 0x11 over word 0xDEADBEEF -> mem_read cycle then mem_write of 0xDEAD7FEF; resp_valid 3 cycles after acceptance.
- Sign/zero extension on word 0xDEAD80EF:
  - lb 0x11 -> 0xFFFFFF80
  - lbu 0x11 -> 0x00000080
  - lh 0x12 -> 0xFFFFDEAD
  - lhu 0x12 -> 0x0000DEAD
- Errors: lh 0x13, sw 0x0E, size 11, read&write both set -> each gives resp_err=1 and resp_data=0, with no mem_read or mem_write. With MEM_ACCESS_BOUNDS_CHECK_EN and MEM_WORDS=32, lw 0x80 -> resp_err=1.
- Reset during RMW_RD of a byte store -> mem_write never asserts, req_ready=1 after reset, and the memory word is unchanged on a subsequent lw.
- Back-to-back: lw accepted in the same cycle as the previous sw's resp_valid -> no lost or duplicated response; req_ready low for exactly the busy cycles.
